// File: rtl/sport_rx.sv
// sport_rx: receive-side SPORT framer.
// Assembles NIBBLES data beats, sampled while the active-low frame sync is low,
// into one WORD_W word. The first beat received lands in the most significant
// nibble. Frames that end early, or run past NIBBLES beats, are flagged.
// Ports:
//   sport_clk  - sole clock, rising edge
//   rst        - synchronous active-high reset
//   FS         - frame sync, active low
//   data       - DATA_W data lane, sampled while FS is low
//   word_out   - last completed word, held between frames
//   word_valid - one-cycle pulse when word_out updates
//   frame_err  - one-cycle pulse on a short or overlong frame
//   busy       - high while the framer is not idle
module sport_rx #(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned NIBBLES = 8
) (
  input  logic                        sport_clk,
  input  logic                        rst,
  input  logic                        FS,
  input  logic [DATA_W-1:0]           data,
  output logic [DATA_W*NIBBLES-1:0]   word_out,
  output logic                        word_valid,
  output logic                        frame_err,
  output logic                        busy
);

  localparam int unsigned WORD_W = DATA_W * NIBBLES;
  localparam int unsigned CNT_W  = $clog2(NIBBLES + 1);
  // History needs only the beats that precede the current one
  localparam int unsigned HIST_W = WORD_W - DATA_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HIST_W-1:0]   shreg_q, shreg_d;
  logic [WORD_W-1:0]   word_d;
  logic                valid_d;
  logic                err_d;
  logic [CNT_W-1:0]    beat_cnt;
  logic [WORD_W-1:0]   shifted;

  // State, counter, history and registered outputs
  always_ff @(posedge sport_clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shreg_q    <= shreg_d;
      word_out   <= word_d;
      word_valid <= valid_d;
      frame_err  <= err_d;
      busy       <= (state_d != S_IDLE);
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    word_d   = word_out;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    beat_cnt = cnt_q + CNT_W'(1);
    shifted  = {shreg_q, data};

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!FS) begin
          shreg_d = shifted[HIST_W-1:0];
          cnt_d   = CNT_W'(1);
          state_d = S_RECV;
        end
      end

      S_RECV: begin
        if (!FS) begin
          shreg_d = shifted[HIST_W-1:0];
          cnt_d   = beat_cnt;
          if (beat_cnt == CNT_W'(NIBBLES)) begin
            word_d  = shifted;
            valid_d = 1'b1;
            state_d = S_HOLD;
          end
        end else begin
          // Short frame: drop the partial word
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      S_HOLD: begin
        if (FS) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(NIBBLES)) begin
          // First overrun beat flags once; count parks at NIBBLES+1 after that
          err_d = 1'b1;
          cnt_d = beat_cnt;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sport_rx.sv
// Bench for sport_rx: directed sequence plus randomized frames, every cycle
// compared against a frame-length model of the receiver.
module tb_sport_rx;

  localparam int unsigned DW  = 4;
  localparam int unsigned NIB = 8;
  localparam int unsigned WW  = DW * NIB;

  logic          sport_clk;
  logic          rst;
  logic          FS;
  logic [DW-1:0] data;
  logic [WW-1:0] word_out;
  logic          word_valid;
  logic          frame_err;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  // Reference model state: length of the current FS-low run and its beats
  int            low_run = 0;
  logic [DW-1:0] beats[$];
  logic [WW-1:0] exp_word = '0;
  logic          exp_valid = 1'b0;
  logic          exp_err = 1'b0;
  logic          exp_busy = 1'b0;

  sport_rx #(.DATA_W(DW), .NIBBLES(NIB)) dut (
    .sport_clk  (sport_clk),
    .rst        (rst),
    .FS         (FS),
    .data       (data),
    .word_out   (word_out),
    .word_valid (word_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial sport_clk = 1'b0;
  always #5 sport_clk = ~sport_clk;

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("word_out", word_out, exp_word);
    chk("word_valid", WW'(word_valid), WW'(exp_valid));
    chk("frame_err", WW'(frame_err), WW'(exp_err));
    chk("busy", WW'(busy), WW'(exp_busy));
    chk("valid_err_exclusive", WW'(word_valid & frame_err), '0);
  endtask

  // One sport_clk cycle: drive on the falling edge, check just after the rising edge
  task automatic step(input logic fs, input logic [DW-1:0] d);
    @(negedge sport_clk);
    rst  = 1'b0;
    FS   = fs;
    data = d;
    @(posedge sport_clk);
    #1;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (!fs) begin
      low_run++;
      if (low_run <= int'(NIB)) beats.push_back(d);
      if (low_run == int'(NIB)) begin
        exp_valid = 1'b1;
        exp_word  = '0;
        for (int i = 0; i < int'(NIB); i++)
          exp_word = exp_word | (WW'(beats[i]) << (DW * (NIB - 1 - i)));
      end
      if (low_run == int'(NIB) + 1) exp_err = 1'b1;
    end else begin
      if (low_run > 0 && low_run < int'(NIB)) exp_err = 1'b1;
      low_run = 0;
      beats.delete();
    end
    // The framer is idle exactly when FS was last sampled high
    exp_busy = !fs;
    compare_all();
  endtask

  task automatic do_reset(input logic fs);
    @(negedge sport_clk);
    rst  = 1'b1;
    FS   = fs;
    data = DW'($urandom);
    @(posedge sport_clk);
    #1;
    low_run = 0;
    beats.delete();
    exp_word  = '0;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    exp_busy  = 1'b0;
    compare_all();
  endtask

  task automatic send_frame(input int len, input logic [DW-1:0] first, input int dir);
    logic [DW-1:0] v;
    v = first;
    for (int i = 0; i < len; i++) begin
      step(1'b0, v);
      v = DW'(int'(v) + dir);
    end
  endtask

  initial begin
    logic [WW-1:0] saved;
    rst  = 1'b1;
    FS   = 1'b1;
    data = '0;

    do_reset(1'b1);
    do_reset(1'b0);

    // Nominal frame after a long idle
    for (int i = 0; i < 100; i++) step(1'b1, DW'($urandom));
    send_frame(8, 4'hF, -1);
    chk("nominal_word", word_out, 32'hFEDCBA98);
    step(1'b1, 4'h0);
    step(1'b1, 4'h0);

    // Short frame keeps the previous word
    send_frame(5, 4'h1, 0);
    step(1'b1, 4'h0);
    chk("short_err", WW'(frame_err), WW'(1));
    chk("short_word_kept", word_out, 32'hFEDCBA98);
    step(1'b1, 4'h0);

    // Overlong frame: word on beat 8, a single error on beat 9
    send_frame(8, 4'h0, 1);
    chk("overlong_word", word_out, 32'h01234567);
    step(1'b0, 4'h8);
    chk("overrun_err", WW'(frame_err), WW'(1));
    step(1'b0, 4'h9);
    step(1'b0, 4'hA);
    step(1'b1, 4'h0);

    // Back-to-back frames with one FS-high cycle between them
    send_frame(8, 4'h1, 1);
    chk("b2b_word1", word_out, 32'h12345678);
    step(1'b1, 4'h0);
    send_frame(8, 4'h8, -1);
    chk("b2b_word2", word_out, 32'h87654321);
    step(1'b1, 4'h0);

    // Reset after beat 4 aborts silently
    send_frame(4, 4'h3, 1);
    do_reset(1'b0);
    step(1'b1, 4'h0);
    send_frame(8, 4'hF, -1);
    chk("post_reset_word", word_out, 32'hFEDCBA98);
    step(1'b1, 4'h0);

    // Idle with toggling data
    saved = word_out;
    for (int i = 0; i < 50; i++) step(1'b1, DW'($urandom));
    chk("idle_word_kept", word_out, saved);

    // Randomized frames of varied length and gap
    for (int f = 0; f < 200; f++) begin
      int len;
      int gap;
      len = (f % 3 == 0) ? int'(NIB) : int'($urandom_range(1, 12));
      gap = int'($urandom_range(0, 3));
      for (int i = 0; i < len; i++) step(1'b0, DW'($urandom));
      if (gap == 0) gap = 1;
      for (int i = 0; i < gap; i++) step(1'b1, DW'($urandom));
      if ($urandom_range(0, 40) == 0) do_reset(1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sport_rx.md
# sport_rx

Receive-side serial-port (SPORT) framer. Samples a 4-bit parallel data lane under an active-low frame sync (FS) and assembles one frame of 8 nibbles into a 32-bit word. It presents each word with a one-cycle valid strobe. The block sits at the input from the SPORT link, ahead of the word-level processing logic, and flags frames whose length is wrong.

## Interface
- DATA_W, 4: data lane width in bits.
- NIBBLES, 8: data beats per frame.
- WORD_W = DATA_W*NIBBLES (32 by default). Derived, not overridable.

Ports:
- sport_clk  input  1  sole clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- FS  input  1  frame sync, active low; low for exactly NIBBLES cycles per valid frame.
- data  input  DATA_W  data lane, sampled while FS low.
- word_out  output  WORD_W  last completed word; first-received beat in the MS nibble.
- word_valid  output  1  one-cycle pulse when word_out updates.
- frame_err  output  1  one-cycle pulse on short or overlong frame.
- busy  output  1  high whenever the FSM is not in IDLE.

## Operation
- One clock and a synchronous active-high reset. FS and data are sampled on the rising edge of sport_clk. The driver changes them on the falling edge.
- The FSM has three states: IDLE, RECV and HOLD.
- IDLE:
  - FS=0 stores the data beat in the shift register, sets beat count to 1 and moves to RECV.
  - FS=1 stays in IDLE.
- RECV, FS=0:
  - The shift register takes {shreg[WORD_W-DATA_W-1:0], data}, and the count increments.
  - If this is beat NIBBLES: word_out takes the full assembled word, word_valid=1 for one cycle, and the FSM moves to HOLD.
- RECV, FS=1 (short frame): the partial word is discarded, word_out is unchanged, frame_err=1 for one cycle, and the FSM moves to IDLE.
- HOLD:
  - FS=1 moves to IDLE.
  - FS=0 (overrun, beat NIBBLES+1) gives frame_err=1 for one cycle only. The FSM stays in HOLD and ignores data until FS=1.
- Back-to-back frames need FS high for at least 1 cycle between them. A frame whose FS low period is adjacent to the previous one is treated as overrun.
- word_out holds its value between frames. It changes only alongside word_valid.
- Beat count width is ceil(log2(NIBBLES+1)). It never wraps, because it is cleared in IDLE.

## Timing
- Reset values: word_out=0, word_valid=0, frame_err=0, busy=0, FSM=IDLE, count=0, shift register=0.
- Reset mid-frame aborts the frame silently: no frame_err and no word_valid. The first FS=0 sample after reset is treated as beat 1.
- Latency: word_valid and the new word_out are registered on the same edge that samples beat NIBBLES. Both are visible in the following cycle.
- frame_err is registered on the edge that samples the offending FS value.
- busy follows the state register. It goes high the cycle after the first FS=0 sample and drops the cycle after FS=1 is sampled in HOLD or RECV.
- word_valid and frame_err are never high together.

## Test plan
- Nominal frame: FS high for 100 cycles, then FS=0 for 8 cycles with data 0xF,0xE,0xD,0xC,0xB,0xA,0x9,0x8, then FS=1. Required: word_out=0xFEDCBA98, word_valid high exactly 1 cycle (after the 8th sample), frame_err stays 0.
- Short frame: FS=0 for 5 beats of 0x1, then FS=1. Required: frame_err pulses once, word_valid stays 0, and word_out keeps its previous value.
- Overlong frame: FS=0 for 11 beats, counting 0x0..0xA. Required: word_valid with word_out=0x01234567, then exactly one frame_err pulse on beat 9, and no further pulses.
- Back-to-back frames: two frames with 1 FS-high cycle between them, data 0x1..0x8 then 0x8..0x1. Required: word_out=0x12345678, then 0x87654321, each with one word_valid pulse.
- Reset mid-frame: assert rst after beat 4, release it with FS high, then send a nominal frame. Required: no pulses during the abort, all outputs read reset values, and the later frame is received correctly.
- Idle with data toggling: FS=1 for 50 cycles with random data. Required: busy=0, no strobes, word_out unchanged.
